// File: rtl/perf_monitor_pkg.sv
// Shared types and encodings for the perf_monitor block.
// State codes double as the value read back through the state select.
package perf_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    // Read-back select encodings for rd_sel_i; codes 5-7 read as zero.
    localparam logic [2:0] SEL_CYCLE  = 3'd0;
    localparam logic [2:0] SEL_STALL  = 3'd1;
    localparam logic [2:0] SEL_FLUSH  = 3'd2;
    localparam logic [2:0] SEL_RETIRE = 3'd3;
    localparam logic [2:0] SEL_STATE  = 3'd4;

endpackage

// File: rtl/perf_monitor_sat_counter.sv
// perf_sat_counter: single event counter with enable, synchronous clear and
// saturation at all-ones (never wraps). Clear wins over enable.
module perf_sat_counter
    import perf_monitor_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear to zero, else step by one unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/perf_monitor.sv
// perf_monitor: CPU pipeline performance counters (cycle, stall, flush and
// optionally retire) with an IDLE/RUN/HALT control FSM, a cycle limit that
// forces HALT, and a snapshot into shadow registers for read-back.
// Optional feature macro: PERF_MONITOR_RETIRE_EN adds the retire counter;
// without it retire_i is ignored and the retire select reads zero.
//
// Snapshot handshake: snap_req_i is sampled on every rising edge in any
// state; each edge that sees it high copies the live counters (values held
// before that edge's increment) into the shadows and raises snap_ack_o for
// exactly the next cycle. There is no ready/back-pressure: back-to-back
// requests yield back-to-back acks. clear_i or rst_i on the same edge cancel
// the copy and the ack.
module perf_monitor
    import perf_monitor_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int CYCLE_LIMIT = 30
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             branch_i,
    input  logic             flush_i,
    input  logic             retire_i,
    input  logic             clear_i,
    input  logic             snap_req_i,
    output logic             snap_ack_o,
    input  logic [2:0]       rd_sel_i,
    output logic [CNT_W-1:0] rd_data_o,
    output logic             halt_o
);

    localparam logic [CNT_W:0] LIMIT_VAL = (CNT_W + 1)'(CYCLE_LIMIT);
    localparam bit             LIMIT_ON  = (CYCLE_LIMIT != 0);

    state_e state_q;
    state_e state_d;
    logic   halt_q;
    logic   halt_d;

    logic   count_en;
    logic   limit_hit;
    logic   stall_en;
    logic   flush_en;

    logic [CNT_W:0]   cycle_inc;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] retire_cnt;

    logic [CNT_W-1:0] shd_cycle_q, shd_cycle_d;
    logic [CNT_W-1:0] shd_stall_q, shd_stall_d;
    logic [CNT_W-1:0] shd_flush_q, shd_flush_d;
    logic [CNT_W-1:0] shd_retire_q, shd_retire_d;
    logic             snap_ack_q, snap_ack_d;

    // A counted edge is any edge with start_i high while IDLE or RUN; the
    // IDLE->RUN edge itself is counted as cycle 1.
    always_comb begin
        count_en  = start_i && ((state_q == ST_IDLE) || (state_q == ST_RUN));
        cycle_inc = {1'b0, cycle_cnt} + (CNT_W + 1)'(1);
        limit_hit = LIMIT_ON && count_en && (cycle_cnt != {CNT_W{1'b1}})
                    && (cycle_inc == LIMIT_VAL);
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: clear returns to IDLE from anywhere; HALT is sticky.
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start_i) state_d = limit_hit ? ST_HALT : ST_RUN;
                ST_RUN:  if (limit_hit) state_d = ST_HALT;
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: per-counter enables and the registered halt flag.
    always_comb begin
        stall_en = count_en && stall_i && !branch_i;
        flush_en = count_en && flush_i;
        halt_d   = (state_d == ST_HALT);
    end

    perf_sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clear_i),
        .en_i  (count_en),
        .cnt_o (cycle_cnt)
    );

    perf_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clear_i),
        .en_i  (stall_en),
        .cnt_o (stall_cnt)
    );

    perf_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clear_i),
        .en_i  (flush_en),
        .cnt_o (flush_cnt)
    );

`ifdef PERF_MONITOR_RETIRE_EN
    logic retire_en;
    assign retire_en = count_en && retire_i;

    perf_sat_counter #(.W(CNT_W)) u_retire_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clear_i),
        .en_i  (retire_en),
        .cnt_o (retire_cnt)
    );
`else
    logic retire_unused;
    assign retire_unused = retire_i;
    assign retire_cnt    = '0;
`endif

    // Snapshot: clear zeros the shadows and cancels the ack; otherwise a
    // request copies the pre-update live values.
    always_comb begin
        shd_cycle_d  = shd_cycle_q;
        shd_stall_d  = shd_stall_q;
        shd_flush_d  = shd_flush_q;
        shd_retire_d = shd_retire_q;
        snap_ack_d   = 1'b0;
        if (clear_i) begin
            shd_cycle_d  = '0;
            shd_stall_d  = '0;
            shd_flush_d  = '0;
            shd_retire_d = '0;
        end else if (snap_req_i) begin
            shd_cycle_d  = cycle_cnt;
            shd_stall_d  = stall_cnt;
            shd_flush_d  = flush_cnt;
            shd_retire_d = retire_cnt;
            snap_ack_d   = 1'b1;
        end
    end

    // Shadow, ack and halt registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shd_cycle_q  <= '0;
            shd_stall_q  <= '0;
            shd_flush_q  <= '0;
            shd_retire_q <= '0;
            snap_ack_q   <= 1'b0;
            halt_q       <= 1'b0;
        end else begin
            shd_cycle_q  <= shd_cycle_d;
            shd_stall_q  <= shd_stall_d;
            shd_flush_q  <= shd_flush_d;
            shd_retire_q <= shd_retire_d;
            snap_ack_q   <= snap_ack_d;
            halt_q       <= halt_d;
        end
    end

    // Read-back mux; the state code is the live FSM state.
    always_comb begin
        rd_data_o = '0;
        case (rd_sel_i)
            SEL_CYCLE:  rd_data_o = shd_cycle_q;
            SEL_STALL:  rd_data_o = shd_stall_q;
            SEL_FLUSH:  rd_data_o = shd_flush_q;
            SEL_RETIRE: rd_data_o = shd_retire_q;
            SEL_STATE:  rd_data_o = CNT_W'(state_q);
            default:    rd_data_o = '0;
        endcase
    end

    assign snap_ack_o = snap_ack_q;
    assign halt_o     = halt_q;

endmodule

// File: tb/tb_perf_monitor.sv
// Testbench for perf_monitor: default instance (CNT_W=32, CYCLE_LIMIT=30)
// plus a narrow instance (CNT_W=4, CYCLE_LIMIT=0) for saturation.
// Expected read-back values are queued when a snapshot is requested and
// popped when the shadow registers are read.
module tb_perf_monitor;

    localparam int W = 32;
`ifdef PERF_MONITOR_RETIRE_EN
    localparam int EXP_RET = 7;
`else
    localparam int EXP_RET = 0;
`endif

    // Clock/reset block
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, start, stall, branch, flush, retire, clear, snap_req;
    logic [2:0]   rd_sel;
    logic         snap_ack, halt;
    logic [W-1:0] rd_data;

    logic         s_rst, s_start, s_snap, s_zero;
    logic [2:0]   s_sel;
    logic         s_ack, s_halt;
    logic [3:0]   s_rd_data;

    perf_monitor #(.CNT_W(32), .CYCLE_LIMIT(30)) u_dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .stall_i    (stall),
        .branch_i   (branch),
        .flush_i    (flush),
        .retire_i   (retire),
        .clear_i    (clear),
        .snap_req_i (snap_req),
        .snap_ack_o (snap_ack),
        .rd_sel_i   (rd_sel),
        .rd_data_o  (rd_data),
        .halt_o     (halt)
    );

    perf_monitor #(.CNT_W(4), .CYCLE_LIMIT(0)) u_dut_small (
        .clk_i      (clk),
        .rst_i      (s_rst),
        .start_i    (s_start),
        .stall_i    (s_zero),
        .branch_i   (s_zero),
        .flush_i    (s_zero),
        .retire_i   (s_zero),
        .clear_i    (s_zero),
        .snap_req_i (s_snap),
        .snap_ack_o (s_ack),
        .rd_sel_i   (s_sel),
        .rd_data_o  (s_rd_data),
        .halt_o     (s_halt)
    );

    // Scoreboard
    logic [W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [W-1:0] got,
                             input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int c, input int s, input int f,
                            input int r, input int st);
        exp_q.push_back(W'(c));
        exp_q.push_back(W'(s));
        exp_q.push_back(W'(f));
        exp_q.push_back(W'(r));
        exp_q.push_back(W'(st));
    endtask

    // Read selects 0..4 and compare against the queued expectations.
    task automatic read_all(input string tag);
        for (int i = 0; i < 5; i++) begin
            rd_sel = 3'(i);
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL %s_sel%0d got=%0d exp=<queue empty>", tag, i, rd_data);
            end else begin
                check_val($sformatf("%s_sel%0d", tag, i), rd_data, exp_q.pop_front());
            end
        end
        rd_sel = 3'd0;
    endtask

    // Driver tasks
    task automatic step(input logic st, input logic sl, input logic br,
                        input logic fl, input logic rt);
        start  = st;
        stall  = sl;
        branch = br;
        flush  = fl;
        retire = rt;
        @(posedge clk);
        #1;
    endtask

    task automatic snap_read(input string tag);
        start    = 1'b0;
        stall    = 1'b0;
        branch   = 1'b0;
        flush    = 1'b0;
        retire   = 1'b0;
        snap_req = 1'b1;
        @(posedge clk);
        #1;
        snap_req = 1'b0;
        check_val({tag, "_ack"}, W'(snap_ack), 1);
        @(posedge clk);
        #1;
        check_val({tag, "_ack_drop"}, W'(snap_ack), 0);
        read_all(tag);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stall = 1'b0; branch = 1'b0; flush = 1'b0;
        retire = 1'b0; clear = 1'b0; snap_req = 1'b0; rd_sel = 3'd0;
        s_rst = 1'b1; s_start = 1'b0; s_snap = 1'b0; s_zero = 1'b0; s_sel = 3'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("rst_halt", W'(halt), 0);
        check_val("rst_ack", W'(snap_ack), 0);
        for (int i = 0; i < 8; i++) begin
            rd_sel = 3'(i);
            #1;
            check_val($sformatf("rst_sel%0d", i), rd_data, 0);
        end
        rd_sel = 3'd0;

        // Ten counted edges, then snapshot while RUN holds with start low
        repeat (10) step(1, 0, 0, 0, 0);
        push_exp(10, 0, 0, 0, 1);
        snap_read("run10");

        // Stall/branch/flush/retire mix: 3 stalls, 2 masked by branch,
        // 2 flushes alongside a masked stall; retire on all 7 edges
        repeat (3) step(1, 1, 0, 0, 1);
        repeat (2) step(1, 1, 1, 0, 1);
        repeat (2) step(1, 1, 1, 1, 1);
        push_exp(17, 3, 2, EXP_RET, 1);
        snap_read("events");

        // Back-to-back snapshot requests each give one ack
        snap_req = 1'b1;
        @(posedge clk); #1;
        check_val("b2b_ack1", W'(snap_ack), 1);
        @(posedge clk); #1;
        snap_req = 1'b0;
        check_val("b2b_ack2", W'(snap_ack), 1);
        @(posedge clk); #1;
        check_val("b2b_ack_drop", W'(snap_ack), 0);

        // Run up to the limit of 30 counted cycles
        repeat (12) step(1, 0, 0, 0, 0);
        check_val("pre_limit_halt", W'(halt), 0);
        step(1, 0, 0, 0, 0);
        check_val("limit_halt", W'(halt), 1);
        repeat (5) step(1, 1, 0, 1, 1);
        check_val("halt_sticky", W'(halt), 1);
        push_exp(30, 3, 2, EXP_RET, 2);
        snap_read("halted");

        // Clear leaves HALT and zeros everything
        clear = 1'b1;
        step(0, 0, 0, 0, 0);
        clear = 1'b0;
        check_val("clr_halt", W'(halt), 0);
        push_exp(0, 0, 0, 0, 0);
        read_all("clr");

        // Snapshot and clear on the same edge at cycle 12
        repeat (12) step(1, 0, 0, 0, 0);
        clear    = 1'b1;
        snap_req = 1'b1;
        step(0, 0, 0, 0, 0);
        clear    = 1'b0;
        snap_req = 1'b0;
        check_val("clrsnap_ack", W'(snap_ack), 0);
        step(0, 0, 0, 0, 0);
        check_val("clrsnap_ack2", W'(snap_ack), 0);
        push_exp(0, 0, 0, 0, 0);
        read_all("clrsnap");

        // Reset mid-RUN with a snapshot pending
        repeat (3) step(1, 1, 0, 1, 1);
        rst      = 1'b1;
        snap_req = 1'b1;
        step(1, 0, 0, 0, 0);
        rst      = 1'b0;
        snap_req = 1'b0;
        check_val("rstsnap_ack", W'(snap_ack), 0);
        step(0, 0, 0, 0, 0);
        check_val("rstsnap_ack2", W'(snap_ack), 0);
        check_val("rstsnap_halt", W'(halt), 0);
        push_exp(0, 0, 0, 0, 0);
        read_all("rstsnap");

        // Narrow instance: 20 counted edges saturate a 4-bit counter at 15
        s_rst = 1'b0;
        s_start = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        s_start = 1'b0;
        s_snap  = 1'b1;
        @(posedge clk); #1;
        s_snap = 1'b0;
        check_val("sat_ack", W'(s_ack), 1);
        s_sel = 3'd0;
        #1;
        check_val("sat_cycle", W'(s_rd_data), 15);
        s_sel = 3'd4;
        #1;
        check_val("sat_state", W'(s_rd_data), 1);
        check_val("sat_halt", W'(s_halt), 0);

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
